// File: rtl/multi_cycle_ctrl.sv
// Main sequencing FSM for the multi-cycle CPU datapath: FETCH/DECODE/EXEC/MEM/WB with a bounded memory wait.
// Optional CTRL_RETIRE_CNT_EN adds a 32-bit retired-instruction counter output.
//
// state  | meaning
// FETCH  | request instruction word, load IR and PC+4 on mem_ready
// DECODE | classify opcode, resolve j/jr/jal/jalr PC load
// EXEC   | branch resolve, ALU operation, address generation
// MEM    | data load/store, waits on mem_ready
// WB     | single-cycle register file write
// ERR    | illegal opcode or bus timeout, held until reset
module multi_cycle_ctrl #(
   parameter int WAIT_LIMIT = 16,
   parameter int WAIT_W     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  op,
   input  logic [4:0]  rt,
   input  logic [5:0]  funct,
   input  logic        mem_ready,
   output logic        pc_write,
   output logic        branch_en,
   output logic        ir_write,
   output logic        mem_req,
   output logic        mem_we,
   output logic        reg_write,
   output logic [1:0]  ext_op,
   output logic [1:0]  pc_src,
   output logic [1:0]  wb_sel,
   output logic [2:0]  state,
   output logic        illegal,
   output logic        bus_err
`ifdef CTRL_RETIRE_CNT_EN
   ,
   output logic [31:0] retired
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_ERR    = 3'd7
   } state_t;

   typedef enum logic [3:0] {
      C_ALU, C_LOAD, C_STORE, C_BRANCH, C_J, C_JR, C_JAL, C_JALR, C_ILL
   } cls_t;

   localparam logic [1:0] EXT_Z   = 2'b00;
   localparam logic [1:0] EXT_S   = 2'b01;
   localparam logic [1:0] EXT_LUI = 2'b10;
   localparam logic [WAIT_W-1:0] WAIT_TC = WAIT_W'(WAIT_LIMIT - 1);

   state_t            state_q;
   state_t            state_nxt;
   cls_t              cls;
   logic [1:0]        ext_d;
   logic [WAIT_W-1:0] wait_cnt;
   logic              wait_tc;
   logic              wait_hit;

   always_comb begin
      cls   = C_ILL;
      ext_d = EXT_Z;
      case (op)
         6'h00: begin
            case (funct)
               6'h00, 6'h02, 6'h04, 6'h06, 6'h21, 6'h23,
               6'h24, 6'h25, 6'h26, 6'h27, 6'h2B: cls = C_ALU;
               6'h03, 6'h07, 6'h2A: begin cls = C_ALU; ext_d = EXT_S; end
               6'h08: cls = C_JR;
               6'h09: cls = C_JALR;
               default: cls = C_ILL;
            endcase
         end
         6'h01: begin
            if (rt == 5'd0 || rt == 5'd1) begin
               cls   = C_BRANCH;
               ext_d = EXT_S;
            end
         end
         6'h02: cls = C_J;
         6'h03: cls = C_JAL;
         6'h04, 6'h05, 6'h06, 6'h07: begin cls = C_BRANCH; ext_d = EXT_S; end
         6'h09, 6'h0A: begin cls = C_ALU; ext_d = EXT_S; end
         6'h0B, 6'h0C, 6'h0D, 6'h0E: cls = C_ALU;
         6'h0F: begin cls = C_ALU; ext_d = EXT_LUI; end
         6'h20, 6'h23: begin cls = C_LOAD; ext_d = EXT_S; end
         6'h24: cls = C_LOAD;
         6'h28, 6'h2B: begin cls = C_STORE; ext_d = EXT_S; end
         default: cls = C_ILL;
      endcase
   end

   assign wait_tc  = !mem_ready && (wait_cnt == WAIT_TC);
   assign wait_hit = mem_req && wait_tc;

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
                   else if (wait_hit) state_nxt = S_ERR;
         S_DECODE: begin
            case (cls)
               C_J, C_JR:     state_nxt = S_FETCH;
               C_JAL, C_JALR: state_nxt = S_WB;
               C_ILL:         state_nxt = S_ERR;
               default:       state_nxt = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls)
               C_BRANCH:       state_nxt = S_FETCH;
               C_LOAD, C_STORE: state_nxt = S_MEM;
               default:        state_nxt = S_WB;
            endcase
         end
         S_MEM:    if (mem_ready) state_nxt = (cls == C_STORE) ? S_FETCH : S_WB;
                   else if (wait_hit) state_nxt = S_ERR;
         S_WB:     state_nxt = S_FETCH;
         S_ERR:    state_nxt = S_ERR;
         default:  state_nxt = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_FETCH;
         wait_cnt <= '0;
         illegal  <= 1'b0;
         bus_err  <= 1'b0;
      end else begin
         state_q <= state_nxt;
         if (mem_req && !mem_ready && state_nxt == state_q)
            wait_cnt <= wait_cnt + 1'b1;
         else
            wait_cnt <= '0;
         if (state_q == S_DECODE && cls == C_ILL)
            illegal <= 1'b1;
         if (wait_hit)
            bus_err <= 1'b1;
      end
   end

`ifdef CTRL_RETIRE_CNT_EN
   logic retire_evt;
   assign retire_evt = (state_q == S_DECODE && (cls == C_J || cls == C_JR))
                    || (state_q == S_EXEC && cls == C_BRANCH)
                    || (state_q == S_MEM && cls == C_STORE && mem_ready)
                    || (state_q == S_WB);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         retired <= '0;
      else if (retire_evt)
         retired <= retired + 32'd1;
   end
`endif

   // Outputs decode straight from state so an async reset lands on FETCH values at once.
   always_comb begin
      pc_write  = 1'b0;
      branch_en = 1'b0;
      ir_write  = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      reg_write = 1'b0;
      ext_op    = EXT_Z;
      pc_src    = 2'b00;
      wb_sel    = 2'b00;
      case (state_q)
         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_DECODE: begin
            ext_op = ext_d;
            case (cls)
               C_J, C_JAL:   begin pc_write = 1'b1; pc_src = 2'b10; end
               C_JR, C_JALR: begin pc_write = 1'b1; pc_src = 2'b11; end
               default: ;
            endcase
         end
         S_EXEC: begin
            ext_op = ext_d;
            if (cls == C_BRANCH) begin
               branch_en = 1'b1;
               pc_src    = 2'b01;
            end
         end
         S_MEM: begin
            ext_op  = ext_d;
            mem_req = 1'b1;
            mem_we  = (cls == C_STORE) && !wait_tc;
         end
         S_WB: begin
            ext_op    = ext_d;
            reg_write = 1'b1;
            if (cls == C_LOAD)
               wb_sel = 2'b01;
            else if (cls == C_JAL || cls == C_JALR)
               wb_sel = 2'b10;
         end
         default: ;
      endcase
   end

   assign state = state_q;

endmodule

// File: doc/multi_cycle_ctrl.md
Name: multi_cycle_ctrl

Overview:
- Main control FSM for the multi-cycle variant of the CPU datapath (shared memory port, IR, PC, register file, ALU, extender).
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives per-state enables, the extender ExtOp and PC/WB select lines.
- Handshakes with the unified memory through a request/ready pair with a bounded wait.

Parameters:
WAIT_LIMIT, 16, max consecutive cycles mem_req may stay unanswered before bus error (1..255).
WAIT_W, 8, width of the wait counter; must satisfy WAIT_LIMIT < 2^WAIT_W.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
op  in  6  IR[31:26], stable from DECODE onward
rt  in  5  IR[20:16]
funct  in  6  IR[5:0]
mem_ready  in  1  memory accepted/returned data this cycle
pc_write  out  1  unconditional PC load
branch_en  out  1  PC load qualified by datapath branch condition
ir_write  out  1  latch memory data into IR
mem_req  out  1  memory access request
mem_we  out  1  write when mem_req=1
reg_write  out  1  register file write
ext_op  out  2  00 ZEXT, 01 SEXT, 10 LUI
pc_src  out  2  00 PC+4, 01 branch target, 10 jump target, 11 rs (jr/jalr)
wb_sel  out  2  00 ALU, 01 memory, 10 PC+4 (link)
state  out  3  current state encoding
illegal  out  1  sticky: unsupported opcode decoded
bus_err  out  1  sticky: memory wait timeout

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=7. Reset: state=FETCH, wait counter=0, illegal=bus_err=0. All outputs are decoded from state, so every enable is 0 in reset except mem_req=1 in FETCH.
- FETCH: mem_req=1, mem_we=0. When mem_ready=1: ir_write=1, pc_write=1, pc_src=00, then go to DECODE. Otherwise stay.
- DECODE: classify the instruction.
  - Supported set: addu subu and or xor nor slt sltu sll srl sra sllv srlv srav jr jalr bgez bltz addiu slti sltiu andi ori xori lui beq bne blez bgtz lb lbu sb lw sw j jal.
  - op=0,funct=0 is sll; an all-zero word executes as a nop.
  - j: pc_write=1, pc_src=10, next state FETCH.
  - jr: pc_write=1, pc_src=11, next state FETCH.
  - jal/jalr: pc_write=1, pc_src=10 for jal or 11 for jalr, next state WB.
  - Unsupported: illegal<=1, next state ERR.
  - All others: next state EXEC.
- EXEC:
  - Branches: branch_en=1, pc_src=01, next state FETCH.
  - Loads/stores: next state MEM.
  - ALU ops: next state WB.
- MEM: mem_req=1, mem_we=1 for sb/sw. When mem_ready=1, stores go to FETCH and loads go to WB. Otherwise stay.
- WB: reg_write=1 for exactly one cycle.
  - wb_sel=01 for loads, 10 for jal/jalr, 00 otherwise.
  - Next state FETCH.
- ext_op: ZEXT for logical/unsigned ops, lbu, sltiu, andi, ori, xori. SEXT for slt, sra, srav, branches, addiu, slti, lb, sb, lw, sw. LUI for lui. Valid in DECODE through WB; 00 in FETCH and ERR.
- Latency (mem_ready immediate):
  - j/jr: 2 cycles.
  - jal/jalr and branches: 3 cycles.
  - ALU ops and stores: 4 cycles.
  - Loads: 5 cycles.
  - Each wait cycle adds 1.
- Wait counter:
  - Increments each cycle mem_req=1 and mem_ready=0.
  - Clears on mem_ready=1 or any state change.
  - Reaching WAIT_LIMIT: bus_err<=1, next state ERR, no enables asserted that cycle.
- ERR: all enables 0, mem_req=0. Held until rst_n asserted.
- Reset mid-operation (any state, including mid-wait): immediate return to FETCH values asynchronously; no partial reg_write or mem_we is issued after rst_n falls.
- mem_ready while mem_req=0 is ignored.

Optional Feature:
CTRL_RETIRE_CNT_EN
- Defined: adds output retired[31:0], reset 0. Increments by 1 on the last cycle of each instruction: DECODE exit for j/jr, EXEC exit for branches, MEM accept for stores, WB for the rest. Wraps 0xFFFFFFFF->0. Never counts in ERR.
- Undefined: no port; all other behaviour is identical.

Test Plan:
- addu (op=0,funct=0x21), mem_ready=1 always -> state 0,1,2,4,0; reg_write=1 only in WB with wb_sel=00, ext_op=00 in DECODE..WB.
- lw (op=0x23) with mem_ready low 2 cycles in MEM -> MEM held 3 cycles, mem_we=0, then WB with wb_sel=01, ext_op=01; 7 cycles total.
- sw (op=0x2B) then beq (op=0x04) -> sw: mem_we=1 in MEM, no reg_write, 4 cycles; beq: branch_en=1, pc_src=01 in EXEC, 3 cycles.
- jal (op=0x03) -> DECODE pc_write=1, pc_src=10; WB reg_write=1, wb_sel=10; lui (op=0x0F) -> ext_op=10.
- op=0x3F -> illegal=1, state=7, all enables 0 for 10 cycles; rst_n pulse -> state=0, illegal=0.
- FETCH with mem_ready held 0 and WAIT_LIMIT=16 -> bus_err=1 and state=7 after 16 cycles; separately, rst_n low mid-MEM wait -> state=0, mem_we=0 at once.
